ccu_clkreq_responder: RTL and testbench
=======================================

# ccu_clkreq_responder

Clock-control-unit responder for the per-slice clkreq/clkack four-phase handshake. Agents raise `clkreq` per slice; this block ramps the slice clock enable, returns `clkack`, and issues a gated `usync` pulse per enabled slice. It sits on the CCU side of `ccu_intf`, opposite the requesting agents, and replaces the behavioural CCU model in the bench.

## Interface
- `NUM_SLICES`, 7: number of independent clock slices.
- `ACK_ON_DLY`, 20: cycles from sampled `clkreq`=1 to `clkack`=1; 0 is treated as 1.
- `ACK_OFF_DLY`, 30: cycles from sampled `clkreq`=0 to `clkack`=0; 0 is treated as 1.
- `USYNC_PERIOD`, 16: `usync` pulse period in cycles, ≥2.

- `clk`  in  1  block clock; all logic on rising edge.
- `global_rst_b`  in  1  reset, synchronous and active-low.
- `pwell_pok`  in  NUM_SLICES  per-slice power-good; low forces slice off.
- `clkreq`  in  NUM_SLICES  per-slice clock request from agent.
- `clkack`  out  NUM_SLICES  per-slice clock acknowledge.
- `clk_en`  out  NUM_SLICES  per-slice clock-gate enable.
- `usync`  out  NUM_SLICES  one-cycle sync pulse, only on enabled slices.
- `proto_err`  out  NUM_SLICES  sticky per-slice handshake violation flag.

## Operation
- Per-slice FSM: OFF, RAMP_UP, ON, RAMP_DOWN. Each slice has its own down-counter, width `$clog2(max(ACK_ON_DLY,ACK_OFF_DLY)+1)`.
- OFF: `clkack`=0, `clk_en`=0. On `clkreq`=1 and `pwell_pok`=1, go to RAMP_UP and load the counter with ACK_ON_DLY-1.
- RAMP_UP: decrement each cycle. At count 0, go to ON. `clkreq` is not re-checked here: a started ramp always completes.
- ON: `clkack`=1, `clk_en`=1. On `clkreq`=0, go to RAMP_DOWN and load the counter with ACK_OFF_DLY-1.
- RAMP_DOWN: `clkack`=1 and `clk_en`=1 are held. At count 0, go to OFF. `clkreq` re-asserting here does not abort; the slice reaches OFF first, then re-arms on the next cycle.
- `pwell_pok`=0 in any state forces OFF on the next edge and clears the counter. `clkreq` is ignored while `pwell_pok`=0.
- usync:
  - A free-running counter counts 0..USYNC_PERIOD-1.
  - `usync[i]` = (counter==USYNC_PERIOD-1) & `clk_en[i]`, registered.
- Protocol violations set `proto_err[i]` (when enabled):
  - `clkreq` falls during RAMP_UP.
  - `clkreq` rises during RAMP_DOWN.
- `proto_err` clears only on reset.
- Slices are fully independent; simultaneous events on different slices do not interact.

## Timing
- Reset values: state OFF; `clkack`=0, `clk_en`=0, `usync`=0, `proto_err`=0; usync counter 0.
- Reset asserted mid-ramp aborts to OFF at that edge with no ack.
- `clkreq`=1 sampled at edge T: `clkack` and `clk_en` are high after edge T+ACK_ON_DLY.
- `clkreq`=0 sampled at edge T (state ON): both low after edge T+ACK_OFF_DLY.
- Minimum re-request gap: `clkreq` sampled high at the first edge after OFF is reached gives RAMP_UP at that edge.
- `pwell_pok` drop sampled at edge T: `clkack`/`clk_en` low after edge T.
- `usync` first pulse: the cycle after edge USYNC_PERIOD-1 post-reset, if the slice is enabled. Period is exactly USYNC_PERIOD, with no drift.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `CCU_RESP_PROTO_CHK_EN`:
  - Defined: violation detection drives `proto_err` as above.
  - Undefined: `proto_err` is tied to 0, the detection logic is removed, and FSM behaviour is identical.

## Test plan
- Reset, then `clkreq[0]`=1 at edge 5, default params: `clkack[0]`/`clk_en[0]` rise after edge 25; other slices stay 0.
- Slice 2 in ON; drop `clkreq[2]` at edge 100: `clkack[2]` falls after edge 130; `usync[2]` pulses stop from then on.
- `clkreq[1]` pulsed high for 3 cycles: ack rises after ACK_ON_DLY, then falls ACK_OFF_DLY later.
  - Macro on: `proto_err[1]`=1.
  - Macro off: `proto_err[1]`=0.
- All 7 slices requested on the same edge: all acks rise on the same cycle; `usync` pulses every 16 cycles on all 7 bits together.
- `pwell_pok[4]`=0 mid-RAMP_UP: slice 4 goes OFF next edge with no ack. `clkreq[4]` held high with pok low gets no response; restoring pok restarts a full ACK_ON_DLY ramp.
- `global_rst_b`=0 for 1 cycle while slices are ON: all outputs are 0 after that edge and `proto_err` is cleared.

Source files
------------

// File: rtl/ccu_clkreq_responder.sv
// rtl/ccu_clkreq_responder.sv - per-slice clkreq/clkack responder with gated usync; CCU_RESP_PROTO_CHK_EN enables proto_err
module ccu_clkreq_responder #(
    parameter int NUM_SLICES   = 7,
    parameter int ACK_ON_DLY   = 20,
    parameter int ACK_OFF_DLY  = 30,
    parameter int USYNC_PERIOD = 16
) (
    input  logic                  clk,
    input  logic                  global_rst_b,
    input  logic [NUM_SLICES-1:0] pwell_pok,
    input  logic [NUM_SLICES-1:0] clkreq,
    output logic [NUM_SLICES-1:0] clkack,
    output logic [NUM_SLICES-1:0] clk_en,
    output logic [NUM_SLICES-1:0] usync,
    output logic [NUM_SLICES-1:0] proto_err
);
    // A zero delay would never terminate a ramp, so it collapses to one cycle.
    localparam int ON_D  = (ACK_ON_DLY  < 1) ? 1 : ACK_ON_DLY;
    localparam int OFF_D = (ACK_OFF_DLY < 1) ? 1 : ACK_OFF_DLY;
    localparam int MAX_D = (ON_D > OFF_D) ? ON_D : OFF_D;
    localparam int CW    = $clog2(MAX_D + 1);
    localparam int UW    = $clog2(USYNC_PERIOD);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_D - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_D - 1);
    localparam logic [UW-1:0] U_LAST   = UW'(USYNC_PERIOD - 1);

    localparam logic [1:0] ST_OFF       = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_ON        = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

    logic [UW-1:0] ucnt;

    always_ff @(posedge clk) begin
        if (!global_rst_b) begin
            ucnt <= '0;
        end else if (ucnt == U_LAST) begin
            ucnt <= '0;
        end else begin
            ucnt <= ucnt + UW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!global_rst_b) begin
            usync <= '0;
        end else begin
            usync <= {NUM_SLICES{ucnt == U_LAST}} & clk_en;
        end
    end

    for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
        logic [1:0]    state;
        logic [CW-1:0] cnt;

        // Loss of power-good overrides every state, including an in-flight ramp.
        always_ff @(posedge clk) begin
            if (!global_rst_b || !pwell_pok[i]) begin
                state <= ST_OFF;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_OFF: begin
                        if (clkreq[i]) begin
                            state <= ST_RAMP_UP;
                            cnt   <= ON_LOAD;
                        end
                    end
                    ST_RAMP_UP: begin
                        if (cnt == '0) begin
                            state <= ST_ON;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    ST_ON: begin
                        if (!clkreq[i]) begin
                            state <= ST_RAMP_DOWN;
                            cnt   <= OFF_LOAD;
                        end
                    end
                    default: begin
                        if (cnt == '0) begin
                            state <= ST_OFF;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                endcase
            end
        end

        assign clk_en[i] = (state == ST_ON) || (state == ST_RAMP_DOWN);
        assign clkack[i] = clk_en[i];

`ifdef CCU_RESP_PROTO_CHK_EN
        logic err;

        // Ramps are entered with clkreq at the opposite level, so any mismatch seen mid-ramp is an edge.
        always_ff @(posedge clk) begin
            if (!global_rst_b) begin
                err <= 1'b0;
            end else if (pwell_pok[i] &&
                         (((state == ST_RAMP_UP) && !clkreq[i]) ||
                          ((state == ST_RAMP_DOWN) && clkreq[i]))) begin
                err <= 1'b1;
            end
        end

        assign proto_err[i] = err;
`else
        assign proto_err[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ccu_clkreq_responder.sv
// tb/tb_ccu_clkreq_responder.sv - scoreboard bench for ccu_clkreq_responder against a deadline-based model
module tb_ccu_clkreq_responder;
    localparam int N     = 7;
    localparam int ON_D  = 20;
    localparam int OFF_D = 30;
    localparam int P     = 16;

    logic         clk = 1'b0;
    logic         global_rst_b = 1'b0;
    logic [N-1:0] pwell_pok = '0;
    logic [N-1:0] clkreq = '0;
    logic [N-1:0] clkack;
    logic [N-1:0] clk_en;
    logic [N-1:0] usync;
    logic [N-1:0] proto_err;

    always #5 clk = ~clk;

    ccu_clkreq_responder #(
        .NUM_SLICES   (N),
        .ACK_ON_DLY   (ON_D),
        .ACK_OFF_DLY  (OFF_D),
        .USYNC_PERIOD (P)
    ) dut (
        .clk          (clk),
        .global_rst_b (global_rst_b),
        .pwell_pok    (pwell_pok),
        .clkreq       (clkreq),
        .clkack       (clkack),
        .clk_en       (clk_en),
        .usync        (usync),
        .proto_err    (proto_err)
    );

    typedef struct {
        logic [N-1:0] ack;
        logic [N-1:0] us;
        logic [N-1:0] err;
        longint       t;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // Model: each slice holds its ack level and, while a transition is pending, the absolute edge at which it lands.
    bit     m_ack  [N];
    bit     m_busy [N];
    bit     m_tgt  [N];
    bit     m_err  [N];
    longint m_dl   [N];
    longint t = 0;
    int     phase = 0;

    task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] req, input longint tt);
        checks++;
        if (act !== req) begin
            $display("FAIL %s edge=%0d actual=%b required=%b", name, tt, act, req);
        end else begin
            passed++;
        end
    endtask

    task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] pok, input logic rst_b);
        exp_t e;
        @(negedge clk);
        clkreq       = req;
        pwell_pok    = pok;
        global_rst_b = rst_b;
        t++;
        for (int i = 0; i < N; i++) begin
            e.us[i] = rst_b && (phase == P - 1) && m_ack[i];
        end
        if (!rst_b) begin
            phase = 0;
            for (int i = 0; i < N; i++) begin
                m_ack[i]  = 0;
                m_busy[i] = 0;
                m_err[i]  = 0;
            end
        end else begin
            phase = (phase + 1) % P;
            for (int i = 0; i < N; i++) begin
                if (!pok[i]) begin
                    m_ack[i]  = 0;
                    m_busy[i] = 0;
                end else if (m_busy[i]) begin
                    if (m_tgt[i] != req[i]) m_err[i] = 1;
                    if (t == m_dl[i]) begin
                        m_ack[i]  = m_tgt[i];
                        m_busy[i] = 0;
                    end
                end else if (req[i] != m_ack[i]) begin
                    m_busy[i] = 1;
                    m_tgt[i]  = req[i];
                    m_dl[i]   = t + (req[i] ? ON_D : OFF_D);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            e.ack[i] = m_ack[i];
`ifdef CCU_RESP_PROTO_CHK_EN
            e.err[i] = m_err[i];
`else
            e.err[i] = 1'b0;
`endif
        end
        e.t = t;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("clkack", clkack, e.ack, e.t);
                cmp("clk_en", clk_en, e.ack, e.t);
                cmp("usync", usync, e.us, e.t);
                cmp("proto_err", proto_err, e.err, e.t);
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        logic [N-1:0] pk;
        rq = '0;
        pk = '1;
        repeat (3) cyc(rq, pk, 1'b0);
        repeat (4) cyc(rq, pk, 1'b1);

        rq[0] = 1'b1;
        repeat (40) cyc(rq, pk, 1'b1);

        rq[2] = 1'b1;
        repeat (40) cyc(rq, pk, 1'b1);
        rq[2] = 1'b0;
        repeat (50) cyc(rq, pk, 1'b1);

        rq[1] = 1'b1;
        repeat (3) cyc(rq, pk, 1'b1);
        rq[1] = 1'b0;
        repeat (80) cyc(rq, pk, 1'b1);

        rq = '0;
        repeat (40) cyc(rq, pk, 1'b1);
        rq = '1;
        repeat (70) cyc(rq, pk, 1'b1);

        rq = '0;
        repeat (40) cyc(rq, pk, 1'b1);
        rq[4] = 1'b1;
        repeat (5) cyc(rq, pk, 1'b1);
        pk[4] = 1'b0;
        repeat (10) cyc(rq, pk, 1'b1);
        pk[4] = 1'b1;
        repeat (30) cyc(rq, pk, 1'b1);

        rq = '1;
        repeat (30) cyc(rq, pk, 1'b1);
        rq[3] = 1'b0;
        repeat (2) cyc(rq, pk, 1'b1);
        cyc(rq, pk, 1'b0);
        repeat (30) cyc(rq, pk, 1'b1);

        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 39) == 0) rq[i] = ~rq[i];
                if (pk[i]) begin
                    if ($urandom_range(0, 299) == 0) pk[i] = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    pk[i] = 1'b1;
                end
            end
            cyc(rq, pk, ($urandom_range(0, 1499) != 0));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end else begin
            passed++;
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
